// File: rtl/bkf_cfg_arbiter.sv
// bkf_cfg_arbiter: round-robin arbiter sharing one BkpCfg write port among N_REQ requesters,
// one outstanding word at a time, completed by an ack edge or aborted by timeout.
module bkf_cfg_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ACK_BIT     = 0,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [32*N_REQ-1:0]  req_index_i,
    input  logic [32*N_REQ-1:0]  req_data_i,
    output logic [N_REQ-1:0]     done_o,
    output logic [N_REQ-1:0]     err_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     err_cnt_o,
    output logic                 bkf_ready,
    output logic [31:0]          bkf_index,
    output logic [31:0]          bkf_data,
    input  logic [31:0]          bk_status_i
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

    state_t         state, state_nx;
    logic [PW-1:0]  ptr, gnt, win;
    logic           any, ack_q, ack_seen, ok, ack_edge, ack, tmo_hit;
    logic [31:0]    tmo_cnt;
    logic [N_REQ-1:0] gnt_oh;

    // Scan downward in priority order so the lowest offset from ptr wins last
    always_comb begin
        any = 1'b0;
        win = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[(32'(ptr) + 32'(i)) % N_REQ]) begin
                any = 1'b1;
                win = PW'((32'(ptr) + 32'(i)) % N_REQ);
            end
        end
    end

    assign ack_edge = bk_status_i[ACK_BIT] & ~ack_q;
    assign ack      = ack_edge | ack_seen;
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_cnt == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = any ? ISSUE : IDLE;
            ISSUE:    state_nx = WAIT_ACK;
            WAIT_ACK: state_nx = (ack || tmo_hit) ? RESP : WAIT_ACK;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            ack_q     <= 1'b0;
            ack_seen  <= 1'b0;
            ok        <= 1'b0;
            tmo_cnt   <= '0;
            bkf_index <= '0;
            bkf_data  <= '0;
            err_cnt_o <= '0;
        end else begin
            state <= state_nx;
            ack_q <= bk_status_i[ACK_BIT];
            case (state)
                IDLE: if (any) begin
                    gnt       <= win;
                    ptr       <= PW'((32'(win) + 1) % N_REQ);
                    bkf_index <= req_index_i[win*32 +: 32];
                    bkf_data  <= req_data_i[win*32 +: 32];
                end
                ISSUE: begin
                    tmo_cnt  <= '0;
                    ack_seen <= ack_edge;
                end
                WAIT_ACK: begin
                    ok       <= ack;
                    ack_seen <= 1'b0;
                    if (!ack) tmo_cnt <= tmo_cnt + 1;
                end
                default: if (!ok && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + 1'b1;
            endcase
        end
    end

    assign gnt_oh    = N_REQ'(1) << gnt;
    assign bkf_ready = (state == ISSUE);
    assign busy_o    = (state != IDLE);
    assign done_o    = (state == RESP && ok) ? gnt_oh : '0;
    assign err_o     = (state == RESP && !ok) ? gnt_oh : '0;
endmodule

// File: tb/tb_bkf_cfg_arbiter.sv
// tb_bkf_cfg_arbiter: directed vector table, hand sequences for reset and saturation,
// then randomized traffic against a transaction-level reference model.
module tb_bkf_cfg_arbiter;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int CW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] ridx, rdat;
    logic [N-1:0]    done, err;
    logic            busy, bkf_ready;
    logic [CW-1:0]   err_cnt;
    logic [31:0]     bkf_index, bkf_data, st;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    bkf_cfg_arbiter #(.N_REQ(N), .ACK_BIT(0), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_index_i(ridx), .req_data_i(rdat),
        .done_o(done), .err_o(err), .busy_o(busy), .err_cnt_o(err_cnt),
        .bkf_ready(bkf_ready), .bkf_index(bkf_index), .bkf_data(bkf_data), .bk_status_i(st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         dly;
        int         g;
        bit         ok;
        bit         keep;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_slices();
        for (int k = 0; k < N; k++) begin
            ridx[32*k +: 32] = 32'h10 + 32'(k);
            rdat[32*k +: 32] = 32'hA5A5_0001 + 32'(k);
        end
    endtask

    task automatic run_txn(input vec_t v);
        bit hit;
        int c, eo;
        logic [31:0] ei, ed;
        logic [N-1:0] oh;
        fill_slices();
        ei = 32'h10 + 32'(v.g);
        ed = 32'hA5A5_0001 + 32'(v.g);
        oh = N'(1) << v.g;
        @(negedge clk);
        req = v.req;
        hit = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
            @(negedge clk);
            hit = bkf_ready;
        end
        chk("issue_seen", 80'(hit), 80'(1));
        chk("bkf_index", 80'(bkf_index), 80'(ei));
        chk("bkf_data", 80'(bkf_data), 80'(ed));
        chk("busy_issue", 80'(busy), 80'(1));
        req  = '0;
        ridx = ~ridx;
        rdat = ~rdat;
        hit  = 1'b0;
        c    = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (i == v.dly) st[0] = 1'b1;
            @(negedge clk);
            c   = i + 1;
            hit = |(done | err);
        end
        eo = v.ok ? ((v.dly <= 1) ? 2 : v.dly + 1) : TMO + 1;
        chk("resp_cyc", 80'(c), 80'(eo));
        chk("done", 80'(done), 80'(v.ok ? oh : '0));
        chk("err", 80'(err), 80'(v.ok ? '0 : oh));
        chk("data_hold", {16'h0, bkf_index, bkf_data}, {16'h0, ei, ed});
        if (!v.keep) st[0] = 1'b0;
        if (!v.ok && ecnt < (1 << CW) - 1) ecnt++;
        @(negedge clk);
        chk("err_cnt", 80'(err_cnt), 80'(ecnt));
        chk("idle", 80'({busy, bkf_ready, done, err}), 80'(0));
    endtask

    // Reference model: tracks the in-flight word by its age since issue
    int          m_age, m_res, m_g, m_ptr, m_cnt;
    bit          m_seen, m_prev;
    logic [31:0] m_idx, m_dat;

    task automatic model_step();
        bit e, found;
        e      = st[0] & ~m_prev;
        m_prev = st[0];
        if (m_res != 0) begin
            if (m_res == 2 && m_cnt < (1 << CW) - 1) m_cnt++;
            m_res = 0;
        end else if (m_age == 0) begin
            found = 1'b0;
            for (int o = 0; o < N; o++) begin
                if (!found && req[(m_ptr + o) % N]) begin
                    found  = 1'b1;
                    m_g    = (m_ptr + o) % N;
                    m_ptr  = (m_g + 1) % N;
                    m_idx  = ridx[32*m_g +: 32];
                    m_dat  = rdat[32*m_g +: 32];
                    m_age  = 1;
                    m_seen = 1'b0;
                end
            end
        end else if (m_age == 1) begin
            m_seen = e;
            m_age  = 2;
        end else if (m_seen || e) begin
            m_res = 1;
            m_age = 0;
        end else if (m_age - 2 == TMO - 1) begin
            m_res = 2;
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        logic [N-1:0] eoh;
        bit hit;
        rst_n = 1'b0;
        req   = '0;
        st    = '0;
        fill_slices();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 80'({busy, bkf_ready, done, err, err_cnt}), 80'(0));
        chk("reset_data", {16'h0, bkf_index, bkf_data}, 80'(0));
        rst_n = 1'b1;

        tbl[0] = '{4'b0001,  1, 0, 1'b1, 1'b0};
        tbl[1] = '{4'b1111,  1, 1, 1'b1, 1'b0};
        tbl[2] = '{4'b0001,  0, 0, 1'b1, 1'b1};
        tbl[3] = '{4'b0001, -1, 0, 1'b0, 1'b0};
        tbl[4] = '{4'b0100, -1, 2, 1'b0, 1'b0};
        tbl[5] = '{4'b1010,  8, 3, 1'b1, 1'b0};
        tbl[6] = '{4'b1010,  3, 1, 1'b1, 1'b0};
        tbl[7] = '{4'b0011,  2, 0, 1'b1, 1'b0};
        foreach (tbl[i]) run_txn(tbl[i]);

        // Drive the error counter into saturation
        for (int i = 0; i < 6; i++) run_txn('{4'b0001, -1, 0, 1'b0, 1'b0});

        // Reset in WAIT_ACK with requester 1 still asserting
        fill_slices();
        @(negedge clk);
        req = 4'b0010;
        hit = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
            @(negedge clk);
            hit = bkf_ready;
        end
        chk("rst_pre_issue", 80'(hit), 80'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 80'({busy, bkf_ready, done, err, err_cnt}), 80'(0));
        chk("rst_mid_data", {16'h0, bkf_index, bkf_data}, 80'(0));
        repeat (2) @(negedge clk);
        chk("rst_hold", 80'({busy, bkf_ready, done, err}), 80'(0));
        rst_n = 1'b1;
        ecnt  = 0;
        @(negedge clk);
        chk("rst_reissue", 80'(bkf_ready), 80'(1));
        chk("rst_reissue_idx", 80'(bkf_index), 80'(32'h11));
        req   = '0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        chk("rst_done", 80'(done), 80'(4'b0010));
        chk("rst_cnt", 80'(err_cnt), 80'(0));

        // Randomized traffic against the model
        rst_n = 1'b0;
        req   = '0;
        st    = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_age  = 0;
        m_res  = 0;
        m_g    = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_seen = 1'b0;
        m_prev = 1'b0;
        m_idx  = '0;
        m_dat  = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            eoh = N'(1) << m_g;
            chk("rnd_ctrl", 80'({busy, bkf_ready, done, err, err_cnt}),
                80'({(m_age != 0 || m_res != 0), (m_age == 1),
                     (m_res == 1) ? eoh : 4'b0, (m_res == 2) ? eoh : 4'b0, CW'(m_cnt)}));
            chk("rnd_data", {16'h0, bkf_index, bkf_data}, {16'h0, m_idx, m_dat});
            for (int k = 0; k < N; k++) if ($urandom_range(3) == 0) req[k] = ~req[k];
            st = {$urandom} & 32'hFFFF_FFFE | {31'h0, st[0] ^ ($urandom_range(4) == 0)};
            for (int k = 0; k < N; k++) begin
                ridx[32*k +: 32] = $urandom;
                rdat[32*k +: 32] = $urandom;
            end
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
